// File: rtl/fpu_mul_iter_if.sv
// Start/finish handshake and operand/result bus for the iterative FP multiplier.
// Start is en (taken only when busy=0); completion is a one-cycle fi with g and flags.
interface fpu_mul_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         en;
    logic         busy;
    logic         fi;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic [3:0]   flags;

    modport master (output en, a, b, input busy, fi, g, flags);
    modport slave  (input en, a, b, output busy, fi, g, flags);
endinterface

// File: rtl/fpu_mul_iter.sv
// Iterative IEEE-style multiplier, shift-add one bit/cycle plus RNE; fi at MAN_W+4 edges after accept (2 for specials).
// No backpressure: en is ignored while busy, result held in g/flags until the next fi.
module fpu_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fpu_mul_iter_if.slave  io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int CW = $clog2(MAN_W + 2);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLASSIFY = 3'd1;
    localparam logic [2:0] S_MULT     = 3'd2;
    localparam logic [2:0] S_NORM     = 3'd3;
    localparam logic [2:0] S_ROUND    = 3'd4;

    logic [2:0]              state;
    logic [W-1:0]            a_r, b_r;
    logic                    sgn;
    logic signed [EW-1:0]    e_r;
    logic [N-1:0]            mcand;
    logic [PW-1:0]           prod;
    logic [CW-1:0]           cnt;
    logic [MAN_W-1:0]        frac_r;
    logic                    grd, stk;
    logic                    spec_hit;
    logic [W-1:0]            spec_g;
    logic [3:0]              spec_f;
    logic [W-1:0]            g_q;
    logic [3:0]              flags_q;
    logic                    fi_q;

    // Operand unpack and special-operand decode
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             is_spec;
    logic [W-1:0]     sp_g;
    logic [3:0]       sp_f;
    logic signed [EW-1:0] e_calc;

    assign {sa, ea, fa} = a_r;
    assign {sb, eb, fb} = b_r;
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign e_calc = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        is_spec = 1'b1;
        sp_g    = '0;
        sp_f    = 4'b0000;
        if (a_nan || b_nan) begin
            sp_g = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            sp_g = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            sp_f = 4'b1000;
        end else if (a_inf || b_inf) begin
            sp_g = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            sp_g = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            is_spec = 1'b0;
        end
    end

    // Shift-add step: multiplier sits in the low half of prod and is consumed LSB first
    logic [N:0] step_sum;
    assign step_sum = {1'b0, prod[PW-1:N]} + (prod[0] ? {1'b0, mcand} : {(N+1){1'b0}});

    // Normalise: product of two [1,2) significands lies in [1,4)
    logic [MAN_W-1:0]     n_frac;
    logic                 n_grd, n_stk;
    logic signed [EW-1:0] n_e;
    always_comb begin
        if (prod[PW-1]) begin
            n_frac = prod[PW-2:N];
            n_grd  = prod[N-1];
            n_stk  = |prod[N-2:0];
            n_e    = e_r + EW'(1);
        end else begin
            n_frac = prod[PW-3:N-1];
            n_grd  = prod[N-2];
            n_stk  = |prod[N-3:0];
            n_e    = e_r;
        end
    end

    // Round to nearest even, then range check on the post-carry exponent
    logic                 r_inc;
    logic [MAN_W:0]       r_sum;
    logic signed [EW-1:0] r_e;
    logic [W-1:0]         r_g;
    logic [3:0]           r_f;
    assign r_inc = grd & (stk | frac_r[0]);
    assign r_sum = {1'b0, frac_r} + {{MAN_W{1'b0}}, r_inc};
    assign r_e   = e_r + $signed({{(EW-1){1'b0}}, r_sum[MAN_W]});

    always_comb begin
        r_g = {sgn, r_e[EXP_W-1:0], r_sum[MAN_W-1:0]};
        r_f = {3'b000, grd | stk};
        if (r_e >= EMAX) begin
            r_g = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_f = 4'b0101;
        end else if (r_e[EW-1] || (r_e == '0)) begin
            r_g = {sgn, {(W-1){1'b0}}};
            r_f = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sgn      <= 1'b0;
            e_r      <= '0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
            frac_r   <= '0;
            grd      <= 1'b0;
            stk      <= 1'b0;
            spec_hit <= 1'b0;
            spec_g   <= '0;
            spec_f   <= '0;
            g_q      <= '0;
            flags_q  <= '0;
            fi_q     <= 1'b0;
        end else begin
            fi_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io.en) begin
                        a_r   <= io.a;
                        b_r   <= io.b;
                        state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    sgn      <= sa ^ sb;
                    e_r      <= e_calc;
                    mcand    <= {1'b1, fa};
                    prod     <= {{N{1'b0}}, 1'b1, fb};
                    cnt      <= '0;
                    spec_hit <= is_spec;
                    spec_g   <= sp_g;
                    spec_f   <= sp_f;
                    state    <= is_spec ? S_ROUND : S_MULT;
                end
                S_MULT: begin
                    prod <= {step_sum, prod[N-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(MAN_W)) state <= S_NORM;
                end
                S_NORM: begin
                    frac_r <= n_frac;
                    grd    <= n_grd;
                    stk    <= n_stk;
                    e_r    <= n_e;
                    state  <= S_ROUND;
                end
                S_ROUND: begin
                    g_q     <= spec_hit ? spec_g : r_g;
                    flags_q <= spec_hit ? spec_f : r_f;
                    fi_q    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.busy  = (state != S_IDLE);
    assign io.fi    = fi_q;
    assign io.g     = g_q;
    assign io.flags = flags_q;
endmodule

// File: tb/tb_fpu_mul_iter.sv
// Directed and randomised checks of fpu_mul_iter (FP32) against hand-computed values and an integer RNE model.
module tb_fpu_mul_iter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fpu_mul_iter_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_mul_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent model: full integer product, remainder-vs-half rounding, flush on underflow
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] mx, my, p;
        logic [24:0] m;
        logic [23:0] rem, half;
        logic        s, ix;
        int          e;
        mx = {24'd0, 1'b1, x[22:0]};
        my = {24'd0, 1'b1, y[22:0]};
        p  = mx * my;
        s  = x[31] ^ y[31];
        e  = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            m = {1'b0, p[47:24]}; rem = p[23:0]; half = 24'h800000; e++;
        end else begin
            m = {1'b0, p[46:23]}; rem = {1'b0, p[22:0]}; half = 24'h400000;
        end
        ix = (rem != 24'd0);
        if (rem > half || (rem == half && m[0])) m++;
        if (m[24]) begin m = m >> 1; e++; end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, ix, s, e[7:0], m[22:0]};
    endfunction

    // Waits from #1 after the accepting edge; returns edges counted until fi (capped)
    task automatic wait_fi(output int n);
        n = 0;
        while (!bus.fi && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eg, input logic [3:0] ef, input int elat);
        int n;
        bus.a = av; bus.b = bv; bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0; bus.a = $urandom; bus.b = $urandom;
        chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
        wait_fi(n);
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_g"}, 64'(bus.g), 64'(eg));
        chk({tag, "_flags"}, 64'(bus.flags), 64'(ef));
        chk({tag, "_busy_at_fi"}, 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_fi_width"}, 64'(bus.fi), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nfi, lat;
        logic [31:0] gcap, ra, rb;
        logic [35:0] exp_r;
        bus.en = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_fi", 64'(bus.fi), 64'(0));
        chk("rst_g", 64'(bus.g), 64'(0));
        chk("rst_flags", 64'(bus.flags), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        run_op("mul_m2x3",   32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27);
        run_op("inexact",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27);
        run_op("overflow",   32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 27);
        run_op("underflow",  32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 27);
        run_op("inf_x_0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
        run_op("0_x_inf",    32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2);
        run_op("nan_x_1",    32'hFFC12345, 32'h3F800000, 32'h7FC00000, 4'b0000, 2);
        run_op("inf_x_m2",   32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2);
        run_op("m0_x_3",     32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 2);

        // en toggling and operand churn while busy must not disturb the running operation
        bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.en = 1'b1;
        @(posedge clk); #1;
        nfi = 0; lat = 0; gcap = '0;
        for (int c = 1; c <= 40; c++) begin
            bus.en = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
            if (bus.fi) begin
                nfi++;
                if (lat == 0) lat = c;
                gcap = bus.g;
            end
        end
        chk("busy_en_fi_count", 64'(nfi), 64'(1));
        chk("busy_en_lat", 64'(lat), 64'(27));
        chk("busy_en_g", 64'(gcap), 64'(32'h40400000));

        // Back-to-back: en held through fi starts the next operation on the following edge
        bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.en = 1'b1;
        @(posedge clk); #1;
        wait_fi(n);
        chk("b2b_first_lat", 64'(n), 64'(27));
        chk("b2b_first_g", 64'(bus.g), 64'(32'h40400000));
        bus.a = 32'hC0000000; bus.b = 32'h40400000;
        @(posedge clk); #1;
        bus.en = 1'b0;
        chk("b2b_second_busy", 64'(bus.busy), 64'(1));
        wait_fi(n);
        chk("b2b_second_lat", 64'(n), 64'(27));
        chk("b2b_second_g", 64'(bus.g), 64'(32'hC0C00000));
        @(posedge clk); #1;

        // Reset mid-operation
        bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_fi", 64'(bus.fi), 64'(0));
        chk("midrst_g", 64'(bus.g), 64'(0));
        chk("midrst_flags", 64'(bus.flags), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        nfi = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.fi) nfi++;
        end
        chk("midrst_no_fi", 64'(nfi), 64'(0));
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);

        // Random normal operands against the integer model
        for (int i = 0; i < 20; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            exp_r = ref_mul(ra, rb);
            run_op($sformatf("rand%0d", i), ra, rb, exp_r[31:0], exp_r[35:32], 27);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
